// File: rtl/updown_cnt_sequencer.sv
// Command sequencer owning a WIDTH-bit up/down counter: GOTO, SWEEP, LOAD, CLEAR.
// One step per RUN edge, done pulses one cycle in DONE; commands accepted only in IDLE.
module updown_cnt_sequencer #(
    parameter int WIDTH  = 3,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [LOOP_W-1:0] cmd_loops,
    input  logic              abort,
    output logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_updown,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [1:0] MODE_GOTO  = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;
    localparam logic [1:0] MODE_LOAD  = 2'd2;
    localparam logic [1:0] MODE_CLEAR = 2'd3;
    localparam logic [WIDTH-1:0] MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, DONE} state_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    cnt_nx, target_q, target_nx;
    logic                updown_nx, aborted_nx, sweep_q, sweep_nx;
    logic [LOOP_W-1:0]   loops_q, loops_nx, loop_q, loop_nx;
    logic [WIDTH-1:0]    cnt_inc, cnt_dec;
    logic [LOOP_W-1:0]   loop_inc;
    logic                accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN_UP) || (state == RUN_DOWN);
    assign done      = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign cnt_dec   = cnt_q - 1'b1;
    assign loop_inc  = loop_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            cnt_updown <= 1'b1;
            aborted    <= 1'b0;
            sweep_q    <= 1'b0;
            target_q   <= '0;
            loops_q    <= '0;
            loop_q     <= '0;
        end else begin
            state      <= state_nx;
            cnt_q      <= cnt_nx;
            cnt_updown <= updown_nx;
            aborted    <= aborted_nx;
            sweep_q    <= sweep_nx;
            target_q   <= target_nx;
            loops_q    <= loops_nx;
            loop_q     <= loop_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt_q;
        updown_nx  = cnt_updown;
        aborted_nx = aborted;
        sweep_nx   = sweep_q;
        target_nx  = target_q;
        loops_nx   = loops_q;
        loop_nx    = loop_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_mode)
                        MODE_GOTO: begin
                            sweep_nx  = 1'b0;
                            target_nx = cmd_target;
                            if (cmd_target > cnt_q) begin
                                state_nx  = RUN_UP;
                                updown_nx = 1'b1;
                            end else if (cmd_target < cnt_q) begin
                                state_nx  = RUN_DOWN;
                                updown_nx = 1'b0;
                            end else begin
                                state_nx  = DONE;
                            end
                        end
                        MODE_SWEEP: begin
                            sweep_nx = 1'b1;
                            loop_nx  = '0;
                            // A loop count of zero still runs one full sweep.
                            loops_nx = (cmd_loops == '0) ? LOOP_W'(1) : cmd_loops;
                            if (cnt_q == MAX) begin
                                state_nx  = RUN_DOWN;
                                updown_nx = 1'b0;
                            end else begin
                                state_nx  = RUN_UP;
                                updown_nx = 1'b1;
                            end
                        end
                        MODE_LOAD: begin
                            cnt_nx   = cmd_target;
                            state_nx = DONE;
                        end
                        MODE_CLEAR: begin
                            cnt_nx   = '0;
                            state_nx = DONE;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
            end
            RUN_UP: begin
                if (abort) begin
                    state_nx   = DONE;
                    aborted_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                    if (sweep_q) begin
                        if (cnt_inc == MAX) begin
                            state_nx  = RUN_DOWN;
                            updown_nx = 1'b0;
                        end
                    end else if (cnt_inc == target_q) begin
                        state_nx = DONE;
                    end
                end
            end
            RUN_DOWN: begin
                if (abort) begin
                    state_nx   = DONE;
                    aborted_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_dec;
                    if (sweep_q) begin
                        if (cnt_dec == '0) begin
                            if (loop_inc == loops_q) begin
                                state_nx = DONE;
                            end else begin
                                loop_nx   = loop_inc;
                                state_nx  = RUN_UP;
                                updown_nx = 1'b1;
                            end
                        end
                    end else if (cnt_dec == target_q) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx   = IDLE;
                aborted_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_updown_cnt_sequencer.sv
// Bench for updown_cnt_sequencer: directed scenarios plus random commands
// checked cycle by cycle against a trajectory model of the counter.
module tb_updown_cnt_sequencer;

    localparam int WIDTH  = 3;
    localparam int LOOP_W = 4;
    localparam int MAX    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [WIDTH-1:0]  cmd_target;
    logic [LOOP_W-1:0] cmd_loops;
    logic              abort;
    logic [WIDTH-1:0]  cnt_q;
    logic              cnt_updown;
    logic              busy;
    logic              done;
    logic              aborted;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt;
    bit m_updown;
    int traj[$];

    updown_cnt_sequencer #(.WIDTH(WIDTH), .LOOP_W(LOOP_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_target(cmd_target), .cmd_loops(cmd_loops),
        .abort(abort), .cnt_q(cnt_q), .cnt_updown(cnt_updown), .busy(busy),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Direction of the i-th counter move in the trajectory (1 = up).
    function automatic bit dir_at(int i, int start);
        int prev;
        prev = (i == 0) ? start : traj[i-1];
        return traj[i] > prev;
    endfunction

    // Counter values after each RUN edge, derived from the command rules.
    task automatic build_traj(input int mode, input int start, input int target, input int loops);
        int pos;
        int eff;
        traj.delete();
        pos = start;
        if (mode == 0) begin
            while (pos < target) begin pos++; traj.push_back(pos); end
            while (pos > target) begin pos--; traj.push_back(pos); end
        end else if (mode == 1) begin
            eff = (loops == 0) ? 1 : loops;
            for (int l = 0; l < eff; l++) begin
                while (pos < MAX) begin pos++; traj.push_back(pos); end
                while (pos > 0)   begin pos--; traj.push_back(pos); end
            end
        end
    endtask

    // Issues one command and follows it to the return to IDLE.
    task automatic run_cmd(input int mode, input int target, input int loops,
                           input int abort_at, input bit hold_valid, input bit abort_on_accept);
        int start;
        int n;
        logic [5:0] got, exp;
        start = m_cnt;
        build_traj(mode, start, target, loops);

        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
        end

        cmd_valid  = 1'b1;
        cmd_mode   = mode[1:0];
        cmd_target = target[WIDTH-1:0];
        cmd_loops  = loops[LOOP_W-1:0];
        abort      = abort_on_accept;
        step();
        abort = 1'b0;
        if (hold_valid && traj.size() > 0) begin
            cmd_mode   = 2'($urandom);
            cmd_target = 3'($urandom);
            cmd_loops  = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end

        if (traj.size() == 0) begin
            if (mode == 2) m_cnt = target;
            else if (mode == 3) m_cnt = 0;
        end else begin
            n = (abort_at >= 0 && abort_at < traj.size()) ? abort_at : traj.size();
            // {busy, done, cnt_updown, cnt_q} in the first RUN cycle
            got = {1'b0, busy, done, cnt_updown, cnt_q};
            exp = {1'b0, 1'b1, 1'b0, dir_at(0, start), 3'(start)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL run_start m%0d t%0d: got %h expected %h", mode, target, got, exp);
            end
            for (int i = 0; i < n; i++) begin
                step();
                if (i < traj.size() - 1) begin
                    got = {1'b0, busy, done, cnt_updown, cnt_q};
                    exp = {1'b0, 1'b1, 1'b0, dir_at(i + 1, start), 3'(traj[i])};
                    n_checks++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL run_step%0d m%0d t%0d: got %h expected %h", i, mode, target, got, exp);
                    end
                end
            end
            if (n < traj.size()) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                m_cnt    = (n == 0) ? start : traj[n-1];
                m_updown = dir_at(n, start);
            end else begin
                m_cnt    = traj[traj.size()-1];
                m_updown = dir_at(traj.size() - 1, start);
            end
            cmd_valid = 1'b0;
        end

        // {busy, done, aborted, cnt_updown, cnt_q} in the DONE cycle
        got = {busy, done, aborted, cnt_updown, cnt_q};
        exp = {1'b0, 1'b1, (traj.size() > 0 && abort_at >= 0 && abort_at < traj.size()),
               m_updown, 3'(m_cnt)};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL done_cycle m%0d t%0d: got %h expected %h", mode, target, got, exp);
        end

        abort = 1'($urandom);
        step();
        abort = 1'b0;
        got = {busy, done, aborted, cnt_updown, cnt_q};
        exp = {1'b0, 1'b0, 1'b0, m_updown, 3'(m_cnt)};
        n_checks++;
        if (got !== exp || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_done m%0d t%0d: got %h rdy %b expected %h rdy 1", mode, target, got, cmd_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_mode = '0; cmd_target = '0; cmd_loops = '0;
        #3;
        n_checks++;
        if ({cnt_q, cnt_updown, busy, done, aborted, cmd_ready} !== 8'b000_1_0_0_0_1) begin
            n_fail++;
            $display("FAIL reset_state: got cnt %0d ud %b busy %b done %b ab %b rdy %b",
                     cnt_q, cnt_updown, busy, done, aborted, cmd_ready);
        end
        step(); step();
        rst = 1'b0;
        m_cnt = 0; m_updown = 1'b1;
    endtask

    task automatic test_goto();
        run_cmd(2, 2, 0, -1, 0, 0);
        run_cmd(0, 5, 0, -1, 0, 0);
        run_cmd(0, 1, 0, -1, 0, 1);
        run_cmd(2, 4, 0, -1, 0, 0);
        run_cmd(0, 4, 0, -1, 0, 1);
    endtask

    task automatic test_sweep();
        run_cmd(3, 0, 0, -1, 0, 0);
        run_cmd(1, 0, 1, -1, 0, 0);
        run_cmd(1, 0, 0, -1, 0, 0);
        run_cmd(1, 0, 2, -1, 0, 0);
        run_cmd(2, 7, 0, -1, 0, 0);
        run_cmd(1, 0, 1, -1, 0, 0);
    endtask

    task automatic test_abort();
        run_cmd(2, 0, 0, -1, 0, 0);
        run_cmd(0, 7, 0, 3, 0, 0);
        run_cmd(1, 0, 3, 0, 0, 0);
        run_cmd(1, 0, 2, 9, 0, 0);
    endtask

    task automatic test_ignore_while_busy();
        run_cmd(0, 0, 0, -1, 1, 0);
        run_cmd(0, 6, 0, -1, 1, 0);
        run_cmd(2, 6, 0, -1, 0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        run_cmd(3, 0, 0, -1, 0, 0);
        cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_loops = 4'd1;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        n_checks++;
        if (cnt_q !== 3'd5) begin
            n_fail++;
            $display("FAIL sweep_pre_reset: got %0d expected 5", cnt_q);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cnt_q, cnt_updown, busy, done, aborted, cmd_ready} !== 8'b000_1_0_0_0_1) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: got cnt %0d ud %b busy %b done %b ab %b rdy %b",
                     cnt_q, cnt_updown, busy, done, aborted, cmd_ready);
        end
        step();
        rst = 1'b0;
        m_cnt = 0; m_updown = 1'b1;
        run_cmd(0, 3, 0, -1, 0, 0);
    endtask

    task automatic test_back_to_back_random();
        int mode, target, loops, abort_at;
        for (int k = 0; k < 60; k++) begin
            mode     = int'($urandom_range(0, 3));
            target   = int'($urandom_range(0, MAX));
            loops    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_cmd(mode, target, loops, abort_at, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_goto();
        test_sweep();
        test_abort();
        test_ignore_while_busy();
        test_reset_mid_sweep();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
